// File: rtl/regfile_param.sv
// Two-read / one-write register file with an optional hardwired-zero entry,
// optional write-to-read bypass and a one-entry-per-cycle clear sweep after reset or clr.

module regfile_param_rdport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0] mem,
  input  logic                               run,
  input  logic [ADDR_W-1:0]                  addr,
  input  logic                               byp_vld,
  input  logic [ADDR_W-1:0]                  byp_addr,
  input  logic [DATA_W-1:0]                  byp_data,
  output logic [DATA_W-1:0]                  rd_data
);
  always_comb begin
    rd_data = mem[addr];
    if (!run || (ZERO_REG != 0 && addr == '0)) rd_data = '0;
    else if (byp_vld && byp_addr == addr)      rd_data = byp_data;
  end
endmodule

module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] a1,
  input  logic [ADDR_W-1:0] a2,
  input  logic [ADDR_W-1:0] a3,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              ready
);
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int NUM_RD = 2;

  typedef enum logic {ST_CLEAR, ST_RUN} state_e;

  state_e                         state_q, state_d;
  logic [ADDR_W-1:0]              ptr_q, ptr_d;
  logic                           ready_q, ready_d;
  logic [DEPTH-1:0][DATA_W-1:0]   mem_q;
  logic                           mem_we;
  logic [ADDR_W-1:0]              mem_wa;
  logic [DATA_W-1:0]              mem_wd;
  logic                           a3_zero, byp_vld;
  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr;
  logic [NUM_RD-1:0][DATA_W-1:0]  rd_data;

  assign a3_zero = (ZERO_REG != 0) && (a3 == '0);

  // clr beats sweep completion, so a clr on the last sweep edge keeps ready low
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ready_d = ready_q;
    if (clr) begin
      state_d = ST_CLEAR;
      ptr_d   = '0;
      ready_d = 1'b0;
    end else if (state_q == ST_CLEAR) begin
      if (ptr_q == ADDR_W'(DEPTH-1)) begin
        state_d = ST_RUN;
        ready_d = 1'b1;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    mem_we = 1'b0;
    mem_wa = a3;
    mem_wd = wr_data;
    if (state_q == ST_CLEAR) begin
      mem_we = 1'b1;
      mem_wa = ptr_q;
      mem_wd = '0;
    end else if (wr_en && !clr && !a3_zero) begin
      mem_we = 1'b1;
    end
  end

  // Storage is deliberately unreset; the sweep owns initialisation.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

  assign byp_vld = (BYPASS != 0) && (state_q == ST_RUN) && wr_en && !a3_zero;
  assign rd_addr = {a2, a1};

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    regfile_param_rdport #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG)
    ) u_rd (
      .mem     (mem_q),
      .run     (ready_q),
      .addr    (rd_addr[i]),
      .byp_vld (byp_vld),
      .byp_addr(a3),
      .byp_data(wr_data),
      .rd_data (rd_data[i])
    );
  end

  assign rd_data1 = rd_data[0];
  assign rd_data2 = rd_data[1];
  assign ready    = ready_q;
endmodule

// File: tb/tb_regfile_param.sv
// Randomised bench for regfile_param: three instances (default, no-zero/no-bypass,
// 16x8) driven in lockstep and compared against an array-based reference model.

module tb_regfile_param;
  localparam int NK = 3;

  logic        clk = 1'b0;
  logic        rst, clr, wr_en;
  logic [4:0]  a1, a2, a3;
  logic [31:0] wr_data;
  logic [31:0] r1_d, r2_d, r1_n, r2_n;
  logic [15:0] r1_s, r2_s;
  logic        rdy_d, rdy_n, rdy_s;

  always #5 clk = ~clk;

  regfile_param u_dut (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .a1(a1), .a2(a2), .a3(a3),
    .wr_data(wr_data), .rd_data1(r1_d), .rd_data2(r2_d), .ready(rdy_d));

  regfile_param #(.ZERO_REG(0), .BYPASS(0)) u_dut_nb (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .a1(a1), .a2(a2), .a3(a3),
    .wr_data(wr_data), .rd_data1(r1_n), .rd_data2(r2_n), .ready(rdy_n));

  regfile_param #(.DATA_W(16), .ADDR_W(3)) u_dut_s (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .a1(a1[2:0]), .a2(a2[2:0]),
    .a3(a3[2:0]), .wr_data(wr_data[15:0]), .rd_data1(r1_s), .rd_data2(r2_s),
    .ready(rdy_s));

  // reference model: per instance config, contents, and edges since sweep start
  int          dw [NK] = '{32, 32, 16};
  int          dep[NK] = '{32, 32, 8};
  bit          zr [NK] = '{1'b1, 1'b0, 1'b1};
  bit          bp [NK] = '{1'b1, 1'b0, 1'b1};
  logic [31:0] m_mem[NK][32];
  int          m_cnt[NK];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] msk(int k);
    return (dw[k] == 32) ? 32'hFFFF_FFFF : ((32'h1 << dw[k]) - 32'h1);
  endfunction

  function automatic int am(int k, logic [4:0] a);
    return int'(a) % dep[k];
  endfunction

  function automatic logic [31:0] exp_rd(int k, logic [4:0] a);
    if (m_cnt[k] < dep[k])                return 32'h0;
    if (zr[k] && am(k, a) == 0)           return 32'h0;
    if (bp[k] && wr_en && am(k, a3) == am(k, a) && !(zr[k] && am(k, a3) == 0))
      return wr_data & msk(k);
    return m_mem[k][am(k, a)];
  endfunction

  function automatic logic [31:0] exp_rdy(int k);
    return (m_cnt[k] >= dep[k]) ? 32'h1 : 32'h0;
  endfunction

  // clearing at sweep start is observationally equal to the one-per-cycle sweep
  task automatic m_restart();
    for (int k = 0; k < NK; k++) begin
      m_cnt[k] = 0;
      for (int i = 0; i < 32; i++) m_mem[k][i] = 32'h0;
    end
  endtask

  task automatic m_edge();
    if (clr) begin
      m_restart();
    end else begin
      for (int k = 0; k < NK; k++) begin
        if (m_cnt[k] < dep[k]) m_cnt[k]++;
        else if (wr_en && !(zr[k] && am(k, a3) == 0))
          m_mem[k][am(k, a3)] = wr_data & msk(k);
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/d.rd1"}, r1_d, exp_rd(0, a1));
    chk({tag, "/d.rd2"}, r2_d, exp_rd(0, a2));
    chk({tag, "/d.rdy"}, 32'(rdy_d), exp_rdy(0));
    chk({tag, "/n.rd1"}, r1_n, exp_rd(1, a1));
    chk({tag, "/n.rd2"}, r2_n, exp_rd(1, a2));
    chk({tag, "/n.rdy"}, 32'(rdy_n), exp_rdy(1));
    chk({tag, "/s.rd1"}, {16'h0, r1_s}, exp_rd(2, a1));
    chk({tag, "/s.rd2"}, {16'h0, r2_s}, exp_rd(2, a2));
    chk({tag, "/s.rdy"}, 32'(rdy_s), exp_rdy(2));
  endtask

  // called at a falling edge; drives, checks before the rising edge, returns at next fall
  task automatic cyc(input string tag, input logic c, input logic we, input logic [4:0] x1,
                     input logic [4:0] x2, input logic [4:0] x3, input logic [31:0] d);
    clr = c; wr_en = we; a1 = x1; a2 = x2; a3 = x3; wr_data = d;
    #1 check_all(tag);
    @(posedge clk);
    m_edge();
    @(negedge clk);
  endtask

  task automatic rnd_cyc(input string tag, input int clr_pct);
    logic [4:0] x1, x2, x3;
    x3 = 5'($urandom_range(0, 31));
    x1 = ($urandom_range(0, 3) == 0) ? x3 : 5'($urandom_range(0, 31));
    x2 = ($urandom_range(0, 3) == 0) ? x3 : 5'($urandom_range(0, 31));
    cyc(tag, ($urandom_range(0, 99) < clr_pct), 1'($urandom_range(0, 1)), x1, x2, x3, $urandom);
  endtask

  task automatic do_reset(input int hold);
    rst = 1'b0;
    m_restart();
    #1 check_all("rst");
    repeat (hold) begin
      @(negedge clk);
      check_all("rst_hold");
    end
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; wr_en = 1'b0; a1 = '0; a2 = '0; a3 = '0; wr_data = '0;
    m_restart();
    @(negedge clk);
    do_reset(2);

    // initial sweep with write attempts that must leave no trace
    repeat (31) rnd_cyc("sweep", 0);
    chk("rdy_at_31", 32'(rdy_d), 32'h0);
    chk("s_rdy_early", 32'(rdy_s), 32'h1);
    cyc("edge32", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
    chk("rdy_at_32", 32'(rdy_d), 32'h1);
    for (int i = 0; i < 32; i++) cyc("rd_all", 1'b0, 1'b0, 5'(i), 5'(31 - i), 5'd0, 32'h0);

    cyc("wr5", 1'b0, 1'b1, 5'd0, 5'd0, 5'd5, 32'h5);
    cyc("wr6", 1'b0, 1'b1, 5'd0, 5'd0, 5'd6, 32'h2);
    wr_en = 1'b0; a1 = 5'd5; a2 = 5'd6;
    #1 chk("r5", r1_d, 32'h5);
    chk("r6", r2_d, 32'h2);
    cyc("rd56", 1'b0, 1'b0, 5'd5, 5'd6, 5'd0, 32'h0);

    cyc("wr0", 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 32'hDEAD_BEEF);
    a1 = 5'd0;
    #1 chk("r0_zero", r1_d, 32'h0);
    chk("r0_nozero", r1_n, 32'hDEAD_BEEF);
    cyc("rd0", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);

    cyc("wr7", 1'b0, 1'b1, 5'd0, 5'd0, 5'd7, 32'h11);
    wr_en = 1'b1; a1 = 5'd7; a2 = 5'd7; a3 = 5'd7; wr_data = 32'h22;
    #1 chk("byp1", r1_d, 32'h22);
    chk("byp2", r2_d, 32'h22);
    chk("nobyp1", r1_n, 32'h11);
    chk("nobyp2", r2_n, 32'h11);
    cyc("byp", 1'b0, 1'b1, 5'd7, 5'd7, 5'd7, 32'h22);
    cyc("post_byp", 1'b0, 1'b0, 5'd7, 5'd7, 5'd0, 32'h0);
    chk("nobyp_late", r1_n, 32'h22);

    // clr in RUN with a simultaneous write that must be dropped
    cyc("clr_wr", 1'b1, 1'b1, 5'd5, 5'd9, 5'd9, 32'h9);
    chk("clr_rdy", 32'(rdy_d), 32'h0);
    repeat (31) rnd_cyc("clr_sweep", 0);
    cyc("clr_last", 1'b0, 1'b0, 5'd5, 5'd9, 5'd0, 32'h0);
    chk("clr_rdy_back", 32'(rdy_d), 32'h1);
    a1 = 5'd5; a2 = 5'd9;
    #1 chk("r5_cleared", r1_d, 32'h0);
    chk("r9_cleared", r2_d, 32'h0);

    // clr landing on the final sweep edge restarts instead of completing
    cyc("clr_a", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
    repeat (31) rnd_cyc("pre_last", 0);
    cyc("clr_on_last", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
    chk("clr_prio", 32'(rdy_d), 32'h0);

    // reset mid-sweep at ptr 10
    repeat (10) rnd_cyc("mid", 0);
    do_reset(3);
    repeat (8) rnd_cyc("re_sweep", 0);
    chk("s_rdy_8", 32'(rdy_s), 32'h1);
    chk("d_rdy_8", 32'(rdy_d), 32'h0);
    repeat (24) rnd_cyc("re_sweep", 0);

    // reset mid-RUN
    repeat (20) rnd_cyc("run", 0);
    do_reset(1);
    repeat (40) rnd_cyc("re_run", 0);

    repeat (2500) rnd_cyc("rand", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
